// File: rtl/cyclic_key_ctrl.sv
// Serial key loader and exhaustive self-check sweep for the cyclically locked c17 core.
// Define CKC_LOCKOUT_EN to add a saturating fail counter and a reset-only LOCK state.
module cyclic_key_ctrl #(
    parameter int KEY_W    = 2,
    parameter int SETTLE   = 4,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_sdi,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             start,
    output logic [4:0]       core_in,
    input  logic [1:0]       core_out,
    output logic [KEY_W-1:0] key_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             locked
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_LOCK   = 3'd5;

    localparam int BW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(KEY_W - 1);
    localparam logic [3:0] SET_LAST = 4'((SETTLE >= 2) ? SETTLE - 2 : 0);
    // With SETTLE=1 a pattern slot is the SAMPLE cycle alone
    localparam logic [2:0] SLOT_ST = (SETTLE > 1) ? S_SETTLE : S_SAMPLE;

    if (SETTLE < 1 || SETTLE > 15 || KEY_W < 1 || MAX_FAIL < 1) begin : g_bad_cfg
        $error("cyclic_key_ctrl: illegal parameter value");
    end

    logic [2:0]       state;
    logic [BW-1:0]    bit_cnt;
    logic [3:0]       settle_cnt;
    logic [KEY_W-1:0] shadow;
    logic [KEY_W-1:0] shadow_nx;
    logic             beat;
    logic             n10, n11, n16, n19;
    logic [1:0]       gold;

    assign n10  = ~(core_in[4] & core_in[2]);
    assign n11  = ~(core_in[2] & core_in[1]);
    assign n16  = ~(core_in[3] & n11);
    assign n19  = ~(n11 & core_in[0]);
    assign gold = {~(n10 & n16), ~(n16 & n19)};

    assign key_ready = (state == S_IDLE) || (state == S_LOAD);
    assign busy      = (state == S_SETTLE) || (state == S_SAMPLE);
    assign beat      = key_ready & key_valid;

    always_comb begin
        shadow_nx = (shadow << 1) | KEY_W'(key_sdi);
    end

`ifdef CKC_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

    logic [FW-1:0] fail_cnt;
    logic [FW-1:0] fail_nx;

    assign fail_nx = (!pass && fail_cnt != FAIL_MAX) ? fail_cnt + 1'b1 : fail_cnt;
    assign locked  = (state == S_LOCK);
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            shadow     <= '0;
            key_out    <= '0;
            core_in    <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
`ifdef CKC_LOCKOUT_EN
            fail_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_LOAD: begin
                    if (beat) begin
                        shadow <= shadow_nx;
                        if (bit_cnt == BIT_LAST) begin
                            key_out <= shadow_nx;
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= S_LOAD;
                        end
                    end else if (state == S_IDLE && start && bit_cnt == '0) begin
                        core_in    <= '0;
                        settle_cnt <= '0;
                        pass       <= 1'b0;
                        state      <= SLOT_ST;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SET_LAST) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (core_out != gold) begin
                        pass  <= 1'b0;
                        state <= S_DONE;
                    end else if (core_in == 5'd31) begin
                        pass  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        core_in    <= core_in + 5'd1;
                        settle_cnt <= '0;
                        state      <= SLOT_ST;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    core_in <= '0;
`ifdef CKC_LOCKOUT_EN
                    fail_cnt <= fail_nx;
                    if (fail_nx == FAIL_MAX) begin
                        key_out <= '0;
                        state   <= S_LOCK;
                    end else begin
                        state <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_LOCK: begin
                    key_out <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cyclic_key_ctrl.md
# cyclic_key_ctrl

Key-load and self-check controller for the cyclically locked c17 core, which has 2 key bits driving the feedback muxes. It accepts the key serially and holds it stable on the core's key inputs. On request, it sweeps all 32 input patterns through the locked core, allowing a settle window per pattern because cyclic keys can make the core oscillate or latch. Each sampled response is compared against an internal golden c17 model, and the block reports pass/fail.

## Interface
Parameters:
- KEY_W, 2, number of key bits (one per key mux)
- SETTLE, 4, cycles a pattern is held before sampling; legal range 1..15
- MAX_FAIL, 3, failed checks before lockout (only with CKC_LOCKOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- key_sdi  in  1  serial key bit, MSB first
- key_valid  in  1  key_sdi valid this cycle
- key_ready  out  1  block accepts a key bit this cycle
- start  in  1  request a self-check (single-cycle pulse or level)
- core_in  out  5  core inputs {N1,N2,N3,N6,N7}, with N1 as the MSB
- core_out  in  2  core outputs {N22,N23}, with N22 as the MSB
- key_out  out  KEY_W  to keyinput[KEY_W-1:0]; bit i drives keyinput i
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at end of a check
- pass  out  1  result of the last check; held until the next start
- locked  out  1  lockout active (tied 0 without the macro)

## Operation
- Reset values:
  - key_out=0, core_in=0, busy=0, done=0, pass=0, locked=0.
  - key_ready=1.
  - Bit counter, pattern counter and fail counter are 0.
- States: IDLE, LOAD, SETTLE, SAMPLE, DONE, LOCK.
- IDLE: key_ready=1.
  - A key_valid beat shifts key_sdi into the shadow register (shadow <= {shadow[KEY_W-2:0], key_sdi}). The bit counter becomes 1 and the state moves to LOAD.
  - start with the bit counter at 0 moves to SETTLE with pattern=0 and busy=1.
- LOAD: key_ready=1 and each accepted beat shifts one more bit in.
  - On the KEY_W-th beat: key_out <= new shadow value in the same edge, the bit counter clears, and the state returns to IDLE.
  - start is ignored while in LOAD; a partial key never reaches key_out.
- SETTLE: core_in=pattern, key_ready=0. The state counts SETTLE-1 cycles, then moves to SAMPLE.
- SAMPLE: core_out is compared with golden(pattern). The golden model is the unlocked c17:
  - N10=~(N1&N3), N11=~(N3&N6), N16=~(N2&N11), N19=~(N11&N7)
  - N22=~(N10&N16), N23=~(N16&N19)
  - On mismatch: pass<=0 and go to DONE (early abort).
  - On match with pattern=31: pass<=1 and go to DONE.
  - Otherwise: pattern+1, back to SETTLE.
- DONE: done=1 for one cycle, busy=0, core_in<=0. On fail, the fail counter increments (saturating). Then go to IDLE.
- key_valid while busy is ignored and no bits are lost from the shadow register. The sender must wait for key_ready.
- start and key_valid in the same IDLE cycle: the key beat wins and start is dropped.
- A start held high after DONE launches a new check.
- rst in any state returns every register to its reset value on the next edge, including key_out.

## Timing
- Key load: exactly KEY_W accepted beats. key_out changes on the edge that accepts the last bit.
- Pattern slot: SETTLE cycles, of which SETTLE-1 are in SETTLE and 1 is in SAMPLE.
- core_in updates on the edge that enters SETTLE. Sampling uses the value present during the SAMPLE cycle.
- Full passing check: start accepted at edge 0, done high in the cycle after edge 32*SETTLE+1. With SETTLE=4 that is 129 cycles.
- Aborted check at pattern p: done in the cycle after edge (p+1)*SETTLE+1.
- pass is valid from the done cycle until the next accepted start, when it clears to 0.
- busy is high from the cycle after start acceptance through the last SAMPLE.

## Configuration
- CKC_LOCKOUT_EN defined:
  - When the saturating fail counter reaches MAX_FAIL, the DONE state goes to LOCK instead of IDLE.
  - In LOCK: locked=1, key_out forced to 0, key_ready=0, start ignored.
  - LOCK exits only on rst.
- CKC_LOCKOUT_EN undefined:
  - No fail counter and no LOCK state; locked is tied to 0.
  - Unlimited retries.

## Test plan
- Reset, then load key bits 0,0 (two beats) and start, with the real locked netlist attached and SETTLE=4: key_out=2'b00, pass=1, done at cycle 129 after start.
- Stub core returning golden outputs except N23 inverted at pattern 5, then start: done at cycle 25, pass=0, core_in returns to 0.
- Load bits 1,0: key_out stays 0 after the first beat and becomes 2'b10 on the second beat. A start between the two beats is ignored.
- key_valid during a running check, then rst mid-check at pattern 10: key_ready=0 during the check and the shadow register is unchanged. After rst: busy=0, core_in=0, key_out=0, pass=0.
- With CKC_LOCKOUT_EN, MAX_FAIL=3 and the failing stub:
  - The third failed check sets locked=1 and key_out=0.
  - Further start and key beats are ignored.
  - rst clears locked.
